// File: rtl/instruction_mem_loader.sv
// Instruction memory write-side loader: packs a valid/ready byte stream MSB-first
// into 32-bit words and writes them at wordIndex*4 while holding the CPU.
module instruction_mem_loader #(
  parameter int numInstructions = 12
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        start,
  input  logic        endLoad,
  input  logic [7:0]  byteIn,
  input  logic        byteValid,
  output logic        byteReady,
  output logic        memWriteEnable,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [31:0] wordsWritten,
  output logic        cpuHold,
  output logic        loadDone
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  localparam logic [31:0] lastWord = 32'(numInstructions - 1);

  state_t      state, stateNext;
  logic [2:0]  byteIdx, byteIdxNext;
  logic [31:0] wordIdx, wordIdxNext;
  logic [31:0] buffer, bufferNext;
  logic [31:0] wordsNext, addrNext, dataNext;
  logic        flush, flushNext;
  logic        accept;
  logic [31:0] shifted;
  logic [2:0]  cnt;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state        <= IDLE;
      byteIdx      <= '0;
      wordIdx      <= '0;
      buffer       <= '0;
      wordsWritten <= '0;
      memAddress   <= '0;
      memWriteData <= '0;
      flush        <= 1'b0;
    end else begin
      state        <= stateNext;
      byteIdx      <= byteIdxNext;
      wordIdx      <= wordIdxNext;
      buffer       <= bufferNext;
      wordsWritten <= wordsNext;
      memAddress   <= addrNext;
      memWriteData <= dataNext;
      flush        <= flushNext;
    end
  end

  always_comb begin
    stateNext      = state;
    byteIdxNext    = byteIdx;
    wordIdxNext    = wordIdx;
    bufferNext     = buffer;
    wordsNext      = wordsWritten;
    addrNext       = memAddress;
    dataNext       = memWriteData;
    flushNext      = flush;
    byteReady      = 1'b0;
    memWriteEnable = 1'b0;
    cpuHold        = 1'b0;
    loadDone       = 1'b0;
    accept         = 1'b0;
    shifted        = buffer;
    cnt            = byteIdx;

    case (state)
      IDLE, DONE: begin
        loadDone = (state == DONE);
        if (start) begin
          stateNext   = COLLECT;
          byteIdxNext = '0;
          wordIdxNext = '0;
          bufferNext  = '0;
          wordsNext   = '0;
          flushNext   = 1'b0;
        end
      end

      COLLECT: begin
        byteReady = 1'b1;
        cpuHold   = 1'b1;
        accept    = byteValid;
        shifted   = accept ? {buffer[23:0], byteIn} : buffer;
        cnt       = byteIdx + {2'b00, accept};
        if (cnt == 3'd4) begin
          stateNext   = WRITE;
          byteIdxNext = cnt;
          bufferNext  = shifted;
          addrNext    = {wordIdx[29:0], 2'b00};
          dataNext    = shifted;
          flushNext   = endLoad;
        end else if (endLoad) begin
          if (cnt == 3'd0) begin
            stateNext = DONE;
          end else begin
            // Left-align the partial word as though zero bytes had followed.
            stateNext   = WRITE;
            byteIdxNext = cnt;
            addrNext    = {wordIdx[29:0], 2'b00};
            flushNext   = 1'b1;
            case (cnt)
              3'd1:    bufferNext = {shifted[7:0], 24'h0};
              3'd2:    bufferNext = {shifted[15:0], 16'h0};
              default: bufferNext = {shifted[23:0], 8'h0};
            endcase
            dataNext = bufferNext;
          end
        end else begin
          byteIdxNext = cnt;
          bufferNext  = shifted;
        end
      end

      WRITE: begin
        memWriteEnable = 1'b1;
        cpuHold        = 1'b1;
        wordIdxNext    = wordIdx + 32'd1;
        wordsNext      = wordsWritten + 32'd1;
        byteIdxNext    = '0;
        bufferNext     = '0;
        flushNext      = 1'b0;
        stateNext      = (wordIdx == lastWord || flush) ? DONE : COLLECT;
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_mem_loader.sv
// Directed bench for instruction_mem_loader: per-cycle vector table plus
// hand-written full-load and mid-load reset sequences.
module tb_instruction_mem_loader;

  logic        clock, resetN, start, endLoad, byteValid;
  logic [7:0]  byteIn;
  logic        byteReady, memWriteEnable, cpuHold, loadDone;
  logic [31:0] memAddress, memWriteData, wordsWritten;

  instruction_mem_loader #(.numInstructions(12)) dut (
    .clock(clock), .resetN(resetN), .start(start), .endLoad(endLoad),
    .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .memWriteEnable(memWriteEnable), .memAddress(memAddress),
    .memWriteData(memWriteData), .wordsWritten(wordsWritten),
    .cpuHold(cpuHold), .loadDone(loadDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic        st, el, bv;
    logic [7:0]  b;
    logic        rdy, we;
    logic [31:0] a, d, ww;
    logic        hold, dn;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] writes[$];
  int          nChecks = 0;
  int          nFails  = 0;

  always @(negedge clock)
    if (resetN && memWriteEnable) writes.push_back({memAddress, memWriteData});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic st, el, bv, input logic [7:0] b, input logic rdy, we,
                     input logic [31:0] a, d, ww, input logic hold, dn);
    vec_t v;
    v = '{st: st, el: el, bv: bv, b: b, rdy: rdy, we: we, a: a, d: d, ww: ww, hold: hold, dn: dn};
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushByte(input logic [7:0] b);
    logic acc;
    bit   ok;
    ok = 0;
    byteValid = 1'b1;
    byteIn    = b;
    for (int i = 0; i < 20; i++) begin
      acc = byteReady;
      tick();
      if (acc) begin ok = 1; break; end
    end
    byteValid = 1'b0;
    if (!ok) chk("pushByte_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic        acc;
    int          sent, cyc;
    logic [31:0] expData;

    resetN = 1'b0; start = 1'b0; endLoad = 1'b0; byteValid = 1'b0; byteIn = 8'h00;
    tick(); tick();
    chk("rst.byteReady", {31'd0, byteReady}, 32'd0);
    chk("rst.memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
    chk("rst.memAddress", memAddress, 32'd0);
    chk("rst.memWriteData", memWriteData, 32'd0);
    chk("rst.wordsWritten", wordsWritten, 32'd0);
    chk("rst.cpuHold", {31'd0, cpuHold}, 32'd0);
    chk("rst.loadDone", {31'd0, loadDone}, 32'd0);
    resetN = 1'b1;
    tick();

    //  st el bv byte   rdy we addr   data          ww  hold dn
    add(1, 0, 0, 8'h00, 1, 0, 32'd0, 32'h0,        32'd0, 1, 0); // 0 start
    add(0, 0, 1, 8'h8C, 1, 0, 32'd0, 32'h0,        32'd0, 1, 0);
    add(0, 0, 1, 8'h01, 1, 0, 32'd0, 32'h0,        32'd0, 1, 0);
    add(0, 0, 1, 8'h00, 1, 0, 32'd0, 32'h0,        32'd0, 1, 0);
    add(0, 0, 1, 8'h04, 0, 1, 32'd0, 32'h8C010004, 32'd0, 1, 0); // 4 write
    add(0, 0, 0, 8'h00, 1, 0, 32'd0, 32'h8C010004, 32'd1, 1, 0);
    add(0, 0, 1, 8'hAB, 1, 0, 32'd0, 32'h8C010004, 32'd1, 1, 0);
    add(0, 0, 1, 8'hCD, 1, 0, 32'd0, 32'h8C010004, 32'd1, 1, 0);
    add(0, 1, 0, 8'h00, 0, 1, 32'd4, 32'hABCD0000, 32'd1, 1, 0); // 8 flush
    add(0, 0, 0, 8'h00, 0, 0, 32'd4, 32'hABCD0000, 32'd2, 0, 1);
    add(0, 0, 1, 8'h55, 0, 0, 32'd4, 32'hABCD0000, 32'd2, 0, 1); // ignored in DONE
    add(1, 0, 0, 8'h00, 1, 0, 32'd4, 32'hABCD0000, 32'd0, 1, 0); // 11 restart
    add(0, 1, 0, 8'h00, 0, 0, 32'd4, 32'hABCD0000, 32'd0, 0, 1); // empty flush
    add(1, 0, 0, 8'h00, 1, 0, 32'd4, 32'hABCD0000, 32'd0, 1, 0);
    add(0, 0, 1, 8'h11, 1, 0, 32'd4, 32'hABCD0000, 32'd0, 1, 0);
    add(0, 0, 1, 8'h22, 1, 0, 32'd4, 32'hABCD0000, 32'd0, 1, 0);
    add(0, 0, 1, 8'h33, 1, 0, 32'd4, 32'hABCD0000, 32'd0, 1, 0);
    add(0, 1, 1, 8'h44, 0, 1, 32'd0, 32'h11223344, 32'd0, 1, 0); // 17 endLoad + 4th
    add(0, 0, 0, 8'h00, 0, 0, 32'd0, 32'h11223344, 32'd1, 0, 1);
    add(0, 0, 0, 8'h00, 0, 0, 32'd0, 32'h11223344, 32'd1, 0, 1); // no padded write
    add(1, 0, 0, 8'h00, 1, 0, 32'd0, 32'h11223344, 32'd0, 1, 0); // 20 start in DONE
    add(0, 0, 1, 8'hAA, 1, 0, 32'd0, 32'h11223344, 32'd0, 1, 0);
    add(0, 0, 1, 8'hBB, 1, 0, 32'd0, 32'h11223344, 32'd0, 1, 0);
    add(0, 0, 1, 8'hCC, 1, 0, 32'd0, 32'h11223344, 32'd0, 1, 0);
    add(0, 0, 1, 8'hDD, 0, 1, 32'd0, 32'hAABBCCDD, 32'd0, 1, 0);
    add(0, 0, 0, 8'h00, 1, 0, 32'd0, 32'hAABBCCDD, 32'd1, 1, 0);
    add(1, 0, 1, 8'h01, 1, 0, 32'd0, 32'hAABBCCDD, 32'd1, 1, 0); // 26 start ignored
    add(0, 0, 1, 8'h02, 1, 0, 32'd0, 32'hAABBCCDD, 32'd1, 1, 0);
    add(0, 0, 1, 8'h03, 1, 0, 32'd0, 32'hAABBCCDD, 32'd1, 1, 0);
    add(0, 0, 1, 8'h04, 0, 1, 32'd4, 32'h01020304, 32'd1, 1, 0);
    add(0, 0, 0, 8'h00, 1, 0, 32'd4, 32'h01020304, 32'd2, 1, 0);
    add(0, 1, 1, 8'h77, 0, 1, 32'd8, 32'h77000000, 32'd2, 1, 0); // 31 byte + flush
    add(0, 0, 0, 8'h00, 0, 0, 32'd8, 32'h77000000, 32'd3, 0, 1);

    foreach (vecs[i]) begin
      start = vecs[i].st; endLoad = vecs[i].el; byteValid = vecs[i].bv; byteIn = vecs[i].b;
      tick();
      chk($sformatf("row%0d.byteReady", i), {31'd0, byteReady}, {31'd0, vecs[i].rdy});
      chk($sformatf("row%0d.memWriteEnable", i), {31'd0, memWriteEnable}, {31'd0, vecs[i].we});
      chk($sformatf("row%0d.memAddress", i), memAddress, vecs[i].a);
      chk($sformatf("row%0d.memWriteData", i), memWriteData, vecs[i].d);
      chk($sformatf("row%0d.wordsWritten", i), wordsWritten, vecs[i].ww);
      chk($sformatf("row%0d.cpuHold", i), {31'd0, cpuHold}, {31'd0, vecs[i].hold});
      chk($sformatf("row%0d.loadDone", i), {31'd0, loadDone}, {31'd0, vecs[i].dn});
    end
    start = 1'b0; endLoad = 1'b0; byteValid = 1'b0;

    // Full 48-byte load with random valid gaps; byte k carries value k.
    start = 1'b1; tick(); start = 1'b0;
    writes.delete();
    sent = 0; cyc = 0;
    while (sent < 48 && cyc < 2000) begin
      byteValid = 1'($urandom_range(0, 1));
      byteIn    = 8'(sent);
      acc = byteValid && byteReady;
      tick();
      if (acc) sent++;
      cyc++;
    end
    byteValid = 1'b0;
    chk("full.bytesSent", sent, 32'd48);
    tick(); tick();
    chk("full.writeCount", writes.size(), 32'd12);
    for (int w = 0; w < 12 && w < writes.size(); w++) begin
      expData = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
      chk($sformatf("full.addr%0d", w), writes[w][63:32], 32'(4*w));
      chk($sformatf("full.data%0d", w), writes[w][31:0], expData);
    end
    chk("full.loadDone", {31'd0, loadDone}, 32'd1);
    chk("full.cpuHold", {31'd0, cpuHold}, 32'd0);
    chk("full.wordsWritten", wordsWritten, 32'd12);
    byteValid = 1'b1; byteIn = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("full.backpressure%0d", i), {31'd0, byteReady}, 32'd0);
    end
    byteValid = 1'b0;
    chk("full.noExtraWrite", writes.size(), 32'd12);

    // Reset while byte 3 of word 5 is on the bus.
    start = 1'b1; tick(); start = 1'b0;
    writes.delete();
    for (int k = 0; k < 22; k++) pushByte(8'(8'h10 + k));
    tick();
    byteValid = 1'b1; byteIn = 8'h99;
    #2 resetN = 1'b0;
    #1;
    chk("midrst.byteReady", {31'd0, byteReady}, 32'd0);
    chk("midrst.memWriteEnable", {31'd0, memWriteEnable}, 32'd0);
    chk("midrst.memAddress", memAddress, 32'd0);
    chk("midrst.memWriteData", memWriteData, 32'd0);
    chk("midrst.wordsWritten", wordsWritten, 32'd0);
    chk("midrst.cpuHold", {31'd0, cpuHold}, 32'd0);
    tick();
    byteValid = 1'b0;
    resetN = 1'b1;
    tick(); tick();
    chk("midrst.writeCount", writes.size(), 32'd5);
    if (writes.size() >= 5) chk("midrst.lastAddr", writes[4][63:32], 32'd16);
    start = 1'b1; tick(); start = 1'b0;
    writes.delete();
    pushByte(8'hDE); pushByte(8'hAD); pushByte(8'hBE); pushByte(8'hEF);
    tick();
    chk("restart.writeCount", writes.size(), 32'd1);
    if (writes.size() >= 1) begin
      chk("restart.addr", writes[0][63:32], 32'd0);
      chk("restart.data", writes[0][31:0], 32'hDEADBEEF);
    end
    chk("restart.wordsWritten", wordsWritten, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
